// File: rtl/pe_tile_feeder.sv
// Transmit side of the systolic-array tile protocol: accepts a tile command plus K paired
// A/B beats, skews them onto the array edges and reports completion after the wavefront drains.
module pe_tile_feeder #(
    parameter int R         = 16,
    parameter int C         = 12,
    parameter int DW        = 16,
    parameter int KW        = 16,
    parameter int DRAIN_LAT = R + C
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [KW-1:0]   cmd_k_i,
    input  logic            a_vec_valid_i,
    output logic            a_vec_ready_o,
    input  logic [R*DW-1:0] a_vec_data_i,
    input  logic            b_vec_valid_i,
    output logic            b_vec_ready_o,
    input  logic [C*DW-1:0] b_vec_data_i,
    output logic            arr_start_o,
    output logic            arr_clear_acc_o,
    output logic [KW-1:0]   arr_k_o,
    output logic [R*DW-1:0] arr_a_data_o,
    output logic [R-1:0]    arr_a_valid_o,
    output logic [C*DW-1:0] arr_b_data_o,
    output logic [C-1:0]    arr_b_valid_o,
    input  logic            arr_done_i,
    output logic            busy_o,
    output logic            tile_done_o
);

    localparam int DCW = $clog2(DRAIN_LAT + 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, WAIT} state_e;

    state_e         state_q;
    logic [KW-1:0]  kLat_q;
    logic [KW-1:0]  beatCnt_q;
    logic [DCW-1:0] drainCnt_q;
    logic           doneSeen_q;
    logic           arrStart_q;
    logic           fire;
    logic           lastBeat;
    logic           doneNow;

    assign fire     = en_i & a_vec_valid_i & b_vec_valid_i & (state_q == STREAM);
    assign lastBeat = (beatCnt_q == kLat_q - KW'(1));
    assign doneNow  = doneSeen_q | arr_done_i;

    // cmd_ready is gated by rstn so that every output reads 0 while reset is held
    assign cmd_ready_o     = rstn & en_i & (state_q == IDLE);
    assign a_vec_ready_o   = fire;
    assign b_vec_ready_o   = fire;
    assign tile_done_o     = en_i & (state_q == WAIT) & doneNow;
    assign busy_o          = (state_q != IDLE);
    assign arr_start_o     = arrStart_q;
    assign arr_clear_acc_o = arrStart_q;
    assign arr_k_o         = kLat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            kLat_q     <= '0;
            beatCnt_q  <= '0;
            drainCnt_q <= '0;
            doneSeen_q <= 1'b0;
            arrStart_q <= 1'b0;
        end else if (en_i) begin
            if (state_q != IDLE && arr_done_i) begin
                doneSeen_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        kLat_q     <= cmd_k_i;
                        beatCnt_q  <= '0;
                        drainCnt_q <= '0;
                        doneSeen_q <= 1'b0;
                        arrStart_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    arrStart_q <= 1'b0;
                    state_q    <= (kLat_q != '0) ? STREAM : DRAIN;
                end
                STREAM: begin
                    if (fire) begin
                        beatCnt_q <= beatCnt_q + KW'(1);
                        if (lastBeat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == DCW'(DRAIN_LAT - 1)) begin
                        state_q <= WAIT;
                    end else begin
                        drainCnt_q <= drainCnt_q + DCW'(1);
                    end
                end
                WAIT: begin
                    if (doneNow) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A lane r is a delay line of r+1 stages; non-fire cycles push a zero bubble
    for (genvar r = 0; r < R; r++) begin : gALane
        logic [DW-1:0] dLine_q [r+1];
        logic          vLine_q [r+1];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= r; j++) begin
                    dLine_q[j] <= '0;
                    vLine_q[j] <= 1'b0;
                end
            end else if (en_i) begin
                dLine_q[0] <= fire ? a_vec_data_i[r*DW +: DW] : '0;
                vLine_q[0] <= fire;
                for (int j = 1; j <= r; j++) begin
                    dLine_q[j] <= dLine_q[j-1];
                    vLine_q[j] <= vLine_q[j-1];
                end
            end
        end

        assign arr_a_data_o[r*DW +: DW] = dLine_q[r];
        assign arr_a_valid_o[r]         = vLine_q[r];
    end

    for (genvar c = 0; c < C; c++) begin : gBLane
        logic [DW-1:0] dLine_q [c+1];
        logic          vLine_q [c+1];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= c; j++) begin
                    dLine_q[j] <= '0;
                    vLine_q[j] <= 1'b0;
                end
            end else if (en_i) begin
                dLine_q[0] <= fire ? b_vec_data_i[c*DW +: DW] : '0;
                vLine_q[0] <= fire;
                for (int j = 1; j <= c; j++) begin
                    dLine_q[j] <= dLine_q[j-1];
                    vLine_q[j] <= vLine_q[j-1];
                end
            end
        end

        assign arr_b_data_o[c*DW +: DW] = dLine_q[c];
        assign arr_b_valid_o[c]         = vLine_q[c];
    end

endmodule

// File: tb/tb_pe_tile_feeder.sv
// Directed bench for pe_tile_feeder on a 2x2 array: lane skew, bubbles, K=0, clock-enable
// freeze, mid-tile reset, and the matrix product rebuilt from the skewed lanes.
module tb_pe_tile_feeder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdK;
    logic        aValid, aReady, bValid, bReady;
    logic [31:0] aData, bData;
    logic        arrStart, arrClear;
    logic [15:0] arrK;
    logic [31:0] arrAData, arrBData;
    logic [1:0]  arrAValid, arrBValid;
    logic        arrDone;
    logic        busy, tileDone;

    int total = 0;
    int bad = 0;
    int doneCount = 0;
    int doneBefore;
    int aCap0[$], aCap1[$], bCap0[$], bCap1[$];

    pe_tile_feeder #(.R(2), .C(2), .DW(16), .KW(16)) dut (
        .clk(clk), .rstn(rstn), .en_i(en),
        .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_k_i(cmdK),
        .a_vec_valid_i(aValid), .a_vec_ready_o(aReady), .a_vec_data_i(aData),
        .b_vec_valid_i(bValid), .b_vec_ready_o(bReady), .b_vec_data_i(bData),
        .arr_start_o(arrStart), .arr_clear_acc_o(arrClear), .arr_k_o(arrK),
        .arr_a_data_o(arrAData), .arr_a_valid_o(arrAValid),
        .arr_b_data_o(arrBData), .arr_b_valid_o(arrBValid),
        .arr_done_i(arrDone), .busy_o(busy), .tile_done_o(tileDone)
    );

    always #5 clk = ~clk;

    // The array consumes lane values only on enabled cycles, so capture only then
    always @(negedge clk) begin
        if (tileDone) doneCount++;
        if (en && rstn) begin
            if (arrAValid[0]) aCap0.push_back(int'(arrAData[15:0]));
            if (arrAValid[1]) aCap1.push_back(int'(arrAData[31:16]));
            if (arrBValid[0]) bCap0.push_back(int'(arrBData[15:0]));
            if (arrBValid[1]) bCap1.push_back(int'(arrBData[31:16]));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic bv,
                                 input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] b0, input logic [15:0] b1);
        aValid = av;
        bValid = bv;
        aData  = {a1, a0};
        bData  = {b1, b0};
    endtask

    task automatic beat(input int k);
        applyStimulus(1'b1, 1'b1, 16'(k + 1), 16'(k + 11), 16'(k + 21), 16'(k + 31));
    endtask

    task automatic idleVec;
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkLanes(input string tag,
                              input logic [15:0] a0, input logic [15:0] a1, input logic [1:0] av,
                              input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] bv);
        #1;
        checkOutput({tag, ".aData"},  64'(arrAData),  64'({a1, a0}));
        checkOutput({tag, ".aValid"}, 64'(arrAValid), 64'(av));
        checkOutput({tag, ".bData"},  64'(arrBData),  64'({b1, b0}));
        checkOutput({tag, ".bValid"}, 64'(arrBValid), 64'(bv));
    endtask

    task automatic waitDone(input string tag, input int expCycles);
        int n = 0;
        while (tileDone !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, ".doneSeen"}, 64'(tileDone), 64'd1);
        checkOutput({tag, ".doneCycle"}, 64'(n), 64'(expCycles));
    endtask

    task automatic clearCaps;
        aCap0.delete(); aCap1.delete(); bCap0.delete(); bCap1.delete();
    endtask

    task automatic checkResult(input string tag, input int k,
                               input int c00, input int c01, input int c10, input int c11);
        int s00 = 0, s01 = 0, s10 = 0, s11 = 0;
        checkOutput({tag, ".aCnt"}, 64'(aCap0.size() + aCap1.size()), 64'(2 * k));
        checkOutput({tag, ".bCnt"}, 64'(bCap0.size() + bCap1.size()), 64'(2 * k));
        for (int i = 0; i < k; i++) begin
            if (i < aCap0.size() && i < aCap1.size() && i < bCap0.size() && i < bCap1.size()) begin
                s00 += aCap0[i] * bCap0[i];
                s01 += aCap0[i] * bCap1[i];
                s10 += aCap1[i] * bCap0[i];
                s11 += aCap1[i] * bCap1[i];
            end
        end
        checkOutput({tag, ".C00"}, 64'(s00), 64'(c00));
        checkOutput({tag, ".C01"}, 64'(s01), 64'(c01));
        checkOutput({tag, ".C10"}, 64'(s10), 64'(c10));
        checkOutput({tag, ".C11"}, 64'(s11), 64'(c11));
    endtask

    initial begin
        // Reset held with busy inputs: every output must stay 0
        rstn = 1'b0; en = 1'b1; cmdValid = 1'b1; cmdK = 16'd5; arrDone = 1'b1;
        beat(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmdValid = ~cmdValid; arrDone = ~arrDone; aValid = ~aValid;
            #1;
            checkOutput("rst.cmdReady", 64'(cmdReady), 64'd0);
            checkOutput("rst.busy", 64'(busy), 64'd0);
            checkOutput("rst.start", 64'(arrStart), 64'd0);
            checkOutput("rst.aValid", 64'({arrAValid, arrBValid}), 64'd0);
            checkOutput("rst.data", 64'({arrAData, arrBData}), 64'd0);
            checkOutput("rst.ready", 64'({aReady, bReady, tileDone}), 64'd0);
        end
        tick();
        rstn = 1'b1; cmdValid = 1'b0; arrDone = 1'b0; idleVec();
        tick();
        checkOutput("rel.busy", 64'(busy), 64'd0);
        checkOutput("rel.cmdReady", 64'(cmdReady), 64'd1);
        checkOutput("rel.arrK", 64'(arrK), 64'd0);

        // Tile 1: K=3 contiguous beats
        clearCaps(); doneBefore = doneCount;
        cmdValid = 1'b1; cmdK = 16'd3;
        #1 checkOutput("t1.cmdReady", 64'(cmdReady), 64'd1);
        tick();
        cmdValid = 1'b0; beat(0);
        #1;
        checkOutput("t1.start", 64'({arrStart, arrClear}), 64'b11);
        checkOutput("t1.arrK", 64'(arrK), 64'd3);
        checkOutput("t1.noReadyInStart", 64'(aReady), 64'd0);
        tick(); beat(0);
        #1 checkOutput("t1.fire0", 64'({aReady, bReady, arrStart}), 64'b110);
        checkLanes("t1.T", 0, 0, 2'b00, 0, 0, 2'b00);
        tick(); beat(1); checkLanes("t1.T1", 1, 0, 2'b01, 21, 0, 2'b01);
        tick(); beat(2); checkLanes("t1.T2", 2, 11, 2'b11, 22, 31, 2'b11);
        tick(); idleVec(); checkLanes("t1.T3", 3, 12, 2'b11, 23, 32, 2'b11);
        tick(); arrDone = 1'b1; checkLanes("t1.T4", 0, 13, 2'b10, 0, 33, 2'b10);
        tick(); arrDone = 1'b0; checkLanes("t1.T5", 0, 0, 2'b00, 0, 0, 2'b00);
        waitDone("t1", 2);
        tick();
        checkOutput("t1.after", 64'({tileDone, cmdReady, busy}), 64'b010);
        checkOutput("t1.doneCnt", 64'(doneCount - doneBefore), 64'd1);
        checkResult("t1", 3, 134, 194, 794, 1154);

        // Tile 2: A stalls for two cycles on the second beat
        clearCaps(); doneBefore = doneCount;
        cmdValid = 1'b1; cmdK = 16'd3;
        tick(); cmdValid = 1'b0;
        tick(); beat(0);
        #1 checkOutput("t2.fire0", 64'(aReady), 64'd1);
        tick(); applyStimulus(1'b0, 1'b1, 16'd2, 16'd12, 16'd22, 16'd32);
        #1 checkOutput("t2.stallReady", 64'({aReady, bReady}), 64'b00);
        checkLanes("t2.T1", 1, 0, 2'b01, 21, 0, 2'b01);
        tick(); checkLanes("t2.T2", 0, 11, 2'b10, 0, 31, 2'b10);
        tick(); beat(1); checkLanes("t2.T3", 0, 0, 2'b00, 0, 0, 2'b00);
        tick(); beat(2); checkLanes("t2.T4", 2, 0, 2'b01, 22, 0, 2'b01);
        tick(); idleVec(); arrDone = 1'b1; checkLanes("t2.T5", 3, 12, 2'b11, 23, 32, 2'b11);
        tick(); arrDone = 1'b0; checkLanes("t2.T6", 0, 13, 2'b10, 0, 33, 2'b10);
        waitDone("t2", 3);
        tick();
        checkOutput("t2.doneCnt", 64'(doneCount - doneBefore), 64'd1);
        checkResult("t2", 3, 134, 194, 794, 1154);

        // Tile 3: K=0, done arrives in the WAIT cycle itself
        doneBefore = doneCount;
        cmdValid = 1'b1; cmdK = 16'd0;
        tick(); cmdValid = 1'b0; beat(0);
        #1 checkOutput("k0.start", 64'({arrStart, arrK}), 64'h10000);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 checkOutput("k0.drain", 64'({aReady, bReady, tileDone, busy}), 64'b0001);
        end
        tick();
        #1 checkOutput("k0.waitNoDone", 64'({tileDone, busy}), 64'b01);
        arrDone = 1'b1;
        #1 checkOutput("k0.sameCycleDone", 64'(tileDone), 64'd1);
        tick(); arrDone = 1'b0; idleVec();
        #1 checkOutput("k0.after", 64'({tileDone, cmdReady, busy}), 64'b010);
        checkOutput("k0.doneCnt", 64'(doneCount - doneBefore), 64'd1);

        // Tile 4: en low in IDLE blocks accept, then en low 5 cycles mid-STREAM
        clearCaps(); doneBefore = doneCount;
        en = 1'b0; cmdValid = 1'b1; cmdK = 16'd3;
        #1 checkOutput("en.idleReady", 64'(cmdReady), 64'd0);
        tick();
        checkOutput("en.idleBusy", 64'(busy), 64'd0);
        en = 1'b1;
        tick(); cmdValid = 1'b0;
        tick(); beat(0);
        #1 checkOutput("en.fire0", 64'(aReady), 64'd1);
        tick(); en = 1'b0; beat(1);
        #1 checkOutput("en.frozenReady", 64'({aReady, tileDone}), 64'b00);
        checkLanes("en.F0", 1, 0, 2'b01, 21, 0, 2'b01);
        for (int i = 1; i < 5; i++) begin
            tick(); checkLanes("en.F", 1, 0, 2'b01, 21, 0, 2'b01);
        end
        tick(); en = 1'b1;
        #1 checkOutput("en.resume", 64'(aReady), 64'd1);
        checkLanes("en.R0", 1, 0, 2'b01, 21, 0, 2'b01);
        tick(); beat(2); checkLanes("en.R1", 2, 11, 2'b11, 22, 31, 2'b11);
        tick(); idleVec(); checkLanes("en.R2", 3, 12, 2'b11, 23, 32, 2'b11);
        tick(); arrDone = 1'b1; checkLanes("en.R3", 0, 13, 2'b10, 0, 33, 2'b10);
        tick(); arrDone = 1'b0;
        waitDone("en", 2);
        tick();
        checkOutput("en.doneCnt", 64'(doneCount - doneBefore), 64'd1);
        checkResult("en", 3, 134, 194, 794, 1154);

        // Tile 5: reset at beat 2 of K=8, then K=2 completes
        cmdValid = 1'b1; cmdK = 16'd8;
        tick(); cmdValid = 1'b0;
        tick(); beat(0);
        tick(); beat(1);
        tick(); beat(2);
        #1 checkOutput("ra.preReady", 64'(aReady), 64'd1);
        doneBefore = doneCount;
        rstn = 1'b0;
        #1;
        checkOutput("ra.ready", 64'({aReady, bReady, cmdReady, tileDone}), 64'd0);
        checkOutput("ra.busy", 64'({busy, arrStart, arrClear}), 64'd0);
        checkOutput("ra.arrK", 64'(arrK), 64'd0);
        checkOutput("ra.lanes", 64'({arrAData, arrBData}), 64'd0);
        checkOutput("ra.valids", 64'({arrAValid, arrBValid}), 64'd0);
        tick(); tick();
        rstn = 1'b1; idleVec();
        tick(); tick(); tick();
        checkOutput("ra.noDone", 64'(doneCount - doneBefore), 64'd0);
        checkOutput("ra.cmdReady", 64'({cmdReady, busy}), 64'b10);
        clearCaps(); doneBefore = doneCount;
        cmdValid = 1'b1; cmdK = 16'd2;
        tick(); cmdValid = 1'b0;
        #1 checkOutput("rb.arrK", 64'(arrK), 64'd2);
        tick(); beat(0);
        tick(); beat(1);
        tick(); idleVec(); arrDone = 1'b1;
        tick(); arrDone = 1'b0;
        waitDone("rb", 3);
        tick();
        checkOutput("rb.doneCnt", 64'(doneCount - doneBefore), 64'd1);
        checkResult("rb", 2, 65, 95, 495, 725);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
